// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 9-bit machine word: type codes, opcodes, field widths.
// Imported by both the control decoder and the program-loader encoder.
package isa_pkg;

  localparam int TYPE_W = 2;
  localparam int OP_W   = 3;
  localparam int OPND_W = 6;
  localparam int WORD_W = 9;

  typedef enum logic [1:0] {
    TYPE_MATH   = 2'b00,
    TYPE_COND   = 2'b01,
    TYPE_ASSIGN = 2'b10,
    TYPE_VALUE  = 2'b11
  } itype_e;

  typedef enum logic [2:0] {
    MATH_ADD = 3'b000,
    MATH_SUB = 3'b001,
    MATH_AND = 3'b010,
    MATH_OR  = 3'b011,
    MATH_XOR = 3'b100,
    MATH_SHL = 3'b101,
    MATH_SHR = 3'b110,
    MATH_NOT = 3'b111
  } math_op_e;

  typedef enum logic [1:0] {
    COND_BL  = 2'b00,
    COND_BG  = 2'b01,
    COND_BNE = 2'b10,
    COND_BEQ = 2'b11
  } cond_op_e;

  // 001, 110 and 111 are reserved in the assign class
  typedef enum logic [2:0] {
    ASG_LI    = 3'b000,
    ASG_LOAD  = 3'b010,
    ASG_STORE = 3'b011,
    ASG_CMP   = 3'b100,
    ASG_NOP   = 3'b101
  } assign_op_e;

  typedef enum logic {
    VAL_MOV = 1'b0,
    VAL_JMP = 1'b1
  } value_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic (type, op, operand) -> 9-bit machine word plus legality.
// Kept free of state so it can double as a reference model.
module instr_pack
  import isa_pkg::*;
(
  input  logic [TYPE_W-1:0] itype,
  input  logic [OP_W-1:0]   op,
  input  logic [OPND_W-1:0] operand,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    unique case (itype_e'(itype))
      TYPE_MATH: begin
        word  = {itype, op, operand[3:0]};
        legal = (operand[5:4] == 2'b00);
      end
      TYPE_COND: begin
        word  = {itype, op[1:0], operand[4:0]};
        legal = !op[2] && !operand[5];
      end
      TYPE_ASSIGN: begin
        word  = {itype, op, operand[3:0]};
        legal = (assign_op_e'(op) inside {ASG_LI, ASG_LOAD, ASG_STORE, ASG_CMP, ASG_NOP})
                && (operand[5:4] == 2'b00);
      end
      TYPE_VALUE: begin
        word  = {itype, op[0], operand};
        legal = (op[2:1] == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes a valid/ready stream of symbolic instructions and writes
// the packed words sequentially into instruction memory, rejecting illegal beats.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [2:0]        in_op,
  input  logic [5:0]        in_operand,
  input  logic              in_last,
  output logic              im_we,
  output logic [AW-1:0]     im_addr,
  output logic [8:0]        im_wdata,
  output logic [AW:0]       word_cnt,
  output logic [7:0]        err_cnt,
  output logic              error,
  output logic              full,
  output logic              done
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  enc_state_e        state;
  logic [AW-1:0]     ptr;
  logic              last_q;
  logic [WORD_W-1:0] word;
  logic              legal;
  logic              accept;
  logic [AW:0]       cnt_nxt;

  instr_pack u_pack (
    .itype   (in_type),
    .op      (in_op),
    .operand (in_operand),
    .word    (word),
    .legal   (legal)
  );

  // A start pulse wins over a beat in the same cycle, so the beat must not be consumed.
  assign in_ready = (state == S_LOAD) && !full && !start;
  assign accept   = in_valid && in_ready;
  assign cnt_nxt  = word_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      last_q   <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
      error    <= 1'b0;
      full     <= 1'b0;
      done     <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (start) begin
        state    <= S_LOAD;
        ptr      <= '0;
        word_cnt <= '0;
        err_cnt  <= '0;
        error    <= 1'b0;
        full     <= 1'b0;
        done     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (accept) begin
              if (legal) begin
                im_we    <= 1'b1;
                im_addr  <= ptr;
                im_wdata <= word;
                last_q   <= in_last;
                state    <= S_WRITE;
              end else begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                error <= 1'b1;
                if (in_last) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          S_WRITE: begin
            ptr      <= ptr + 1'b1;
            word_cnt <= cnt_nxt;
            if (cnt_nxt == DEPTH_CNT) full <= 1'b1;
            if (last_q || (cnt_nxt == DEPTH_CNT)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a full-size instance plus a DEPTH=4 instance for the full boundary.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_type = '0;
  logic [2:0] in_op = '0;
  logic [5:0] in_operand = '0;
  logic       in_last = 1'b0;

  logic       in_ready, im_we, error, full, done;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic [8:0] word_cnt;
  logic [7:0] err_cnt;

  logic       in_ready4, im_we4, error4, full4, done4;
  logic [1:0] im_addr4;
  logic [8:0] im_wdata4;
  logic [2:0] word_cnt4;
  logic [7:0] err_cnt4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic sel4 = 1'b0;
  logic rdy;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int wr4_addr[$];
  int acc_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rdy = sel4 ? in_ready4 : in_ready;

  instr_encoder u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_op(in_op), .in_operand(in_operand), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .word_cnt(word_cnt),
    .err_cnt(err_cnt), .error(error), .full(full), .done(done)
  );

  instr_encoder #(.AW(2), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_type(in_type), .in_op(in_op), .in_operand(in_operand), .in_last(in_last),
    .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4), .word_cnt(word_cnt4),
    .err_cnt(err_cnt4), .error(error4), .full(full4), .done(done4)
  );

  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(int'(im_wdata));
      wr_cyc.push_back(cyc);
    end
    if (im_we4) wr4_addr.push_back(int'(im_addr4));
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr4_addr.delete(); acc_cyc.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    clear_logs();
  endtask

  task automatic send(input logic [1:0] t, input logic [2:0] o, input logic [5:0] d,
                      input logic l);
    bit ok = 0;
    in_valid = 1'b1; in_type = t; in_op = o; in_operand = d; in_last = l;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sel4 ? done4 : done) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    // reset state, and beats in IDLE are ignored
    #12;
    chk("rst_we", int'(im_we), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_wcnt", int'(word_cnt), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk); reset_n = 1'b1;
    in_valid = 1'b1; in_type = 2'b00; in_operand = 6'h1;
    repeat (4) @(negedge clk);
    chk("idle_ready", int'(in_ready), 0);
    chk("idle_writes", wr_addr.size(), 0);
    in_valid = 1'b0;

    // basic program, one of each class
    pulse_start();
    send(2'b00, 3'b000, 6'h05, 1'b0);
    send(2'b01, 3'b011, 6'h12, 1'b0);
    send(2'b10, 3'b000, 6'h09, 1'b0);
    send(2'b11, 3'b001, 6'h3F, 1'b1);
    wait_done("prog");
    chk("prog_nwr", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      chk("prog_a0", wr_addr[0], 0); chk("prog_d0", wr_data[0], 'h005);
      chk("prog_a1", wr_addr[1], 1); chk("prog_d1", wr_data[1], 'h0F2);
      chk("prog_a2", wr_addr[2], 2); chk("prog_d2", wr_data[2], 'h109);
      chk("prog_a3", wr_addr[3], 3); chk("prog_d3", wr_data[3], 'h1FF);
    end
    chk("prog_wcnt", int'(word_cnt), 4);
    chk("prog_done", int'(done), 1);
    chk("prog_err", int'(error), 0);

    // reserved assign op between two math beats
    pulse_start();
    chk("start_clr_wcnt", int'(word_cnt), 0);
    chk("start_clr_done", int'(done), 0);
    send(2'b00, 3'b001, 6'h03, 1'b0);
    send(2'b10, 3'b110, 6'h01, 1'b0);
    send(2'b00, 3'b010, 6'h04, 1'b1);
    wait_done("rsv");
    chk("rsv_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("rsv_a0", wr_addr[0], 0); chk("rsv_d0", wr_data[0], 'h013);
      chk("rsv_a1", wr_addr[1], 1); chk("rsv_d1", wr_data[1], 'h024);
    end
    chk("rsv_errcnt", int'(err_cnt), 1);
    chk("rsv_error", int'(error), 1);
    chk("rsv_wcnt", int'(word_cnt), 2);

    // three rejected beats: cond op[2], cond operand[5], math operand[4]
    pulse_start();
    send(2'b01, 3'b100, 6'h01, 1'b0);
    send(2'b01, 3'b000, 6'h20, 1'b0);
    send(2'b00, 3'b000, 6'h10, 1'b1);
    wait_done("rej");
    chk("rej_errcnt", int'(err_cnt), 3);
    chk("rej_nwr", wr_addr.size(), 0);
    chk("rej_wcnt", int'(word_cnt), 0);
    chk("rej_error", int'(error), 1);

    // DEPTH=4 instance: six legal beats, no last
    sel4 = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send(2'b00, 3'b000, 6'(i), 1'b0);
    wait_done("full");
    in_valid = 1'b1; in_type = 2'b00; in_op = 3'b000; in_operand = 6'h4;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("full_ready_low", int'(in_ready4), 0);
    end
    in_valid = 1'b0;
    chk("full_nwr", wr4_addr.size(), 4);
    for (int i = 0; i < wr4_addr.size() && i < 4; i++) chk("full_addr", wr4_addr[i], i);
    chk("full_flag", int'(full4), 1);
    chk("full_done", int'(done4), 1);
    chk("full_wcnt", int'(word_cnt4), 4);
    sel4 = 1'b0;

    // continuous valid: accept every other cycle, write one cycle after accept
    pulse_start();
    in_valid = 1'b1; in_type = 2'b00; in_op = 3'b011; in_operand = 6'h7; in_last = 1'b0;
    repeat (12) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("tput_nacc", acc_cyc.size(), 6);
    chk("tput_nwr", wr_cyc.size(), 6);
    for (int i = 0; i < acc_cyc.size() && i < wr_cyc.size(); i++)
      chk("tput_lat", wr_cyc[i] - acc_cyc[i], 1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("tput_gap", acc_cyc[i] - acc_cyc[i-1], 2);
    if (wr_data.size() > 0) chk("tput_data", wr_data[0], 'h037);

    // async reset in the middle of a WRITE
    pulse_start();
    send(2'b00, 3'b000, 6'h01, 1'b0);
    in_valid = 1'b1; in_type = 2'b11; in_op = 3'b000; in_operand = 6'h2A;
    begin
      bit seen = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (im_we && im_addr == 8'd1) begin seen = 1; break; end
      end
      chk("mid_write_seen", int'(seen), 1);
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_we", int'(im_we), 0);
    chk("arst_addr", int'(im_addr), 0);
    chk("arst_wdata", int'(im_wdata), 0);
    chk("arst_wcnt", int'(word_cnt), 0);
    chk("arst_ready", int'(in_ready), 0);
    @(negedge clk); reset_n = 1'b1;
    pulse_start();
    send(2'b11, 3'b000, 6'h2A, 1'b1);
    wait_done("rerun");
    chk("rerun_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("rerun_a0", wr_addr[0], 0);
      chk("rerun_d0", wr_data[0], 'h1AA);
    end
    chk("rerun_wcnt", int'(word_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart of the processor's control decoder.
- Accepts symbolic instructions (type, opcode, operand) over a valid/ready stream and packs each into the 9-bit machine word the decoder consumes.
- Writes the packed words sequentially into the instruction-memory write port; used as the program loader ahead of reset-release of the core.
- Reserved opcodes and operands wider than their field are rejected and counted, not written.

Parameters:
- AW, 8, instruction-memory address width.
- DEPTH, 256, number of writable words; must satisfy DEPTH <= 2**AW.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load at address 0.
- in_valid  in  1  source has a beat.
- in_ready  out  1  encoder accepts a beat this cycle.
- in_type  in  2  instruction class: 00 math, 01 cond, 10 assign, 11 value.
- in_op  in  3  opcode within the class.
- in_operand  in  6  operand value, right-aligned.
- in_last  in  1  marks the final beat of the program.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  AW  write address.
- im_wdata  out  9  encoded machine word.
- word_cnt  out  AW+1  words written since start.
- err_cnt  out  8  beats rejected since start; saturates at 255.
- error  out  1  sticky; set on any rejected beat, cleared by start.
- full  out  1  DEPTH words written.
- done  out  1  high in DONE state.

Behaviour:
- Encoding: word[8:7]=in_type.
  - Math (00): word[6:4]=in_op, word[3:0]=operand[3:0]; legal only if operand[5:4]==0.
  - Cond (01): word[6:5]=in_op[1:0], word[4:0]=operand[4:0]; legal only if in_op[2]==0 and operand[5]==0. Ops: 00 bl, 01 bg, 10 bne, 11 beq.
  - Assign (10): word[6:4]=in_op, word[3:0]=operand[3:0]; legal ops are 000 li, 010 load, 011 store, 100 cmp, 101 nop. Ops 001, 110 and 111 are reserved and illegal. Also illegal if operand[5:4]!=0.
  - Value (11): word[6]=in_op[0], word[5:0]=operand; legal only if in_op[2:1]==0. Ops: 0 mov, 1 jmp.
- Reset: state=IDLE; all outputs 0; address pointer 0; counters 0.
- FSM states: IDLE, LOAD, WRITE, DONE.
  - IDLE: in_ready=0. start moves to LOAD; pointer, word_cnt, err_cnt, error, full and done all cleared.
  - LOAD: in_ready=1 (0 if full). On in_valid&in_ready, capture the beat and encode it into registers.
    - Legal beat: go to WRITE.
    - Illegal beat: no write; err_cnt++ (saturating), error=1. Go to DONE if in_last, else stay in LOAD.
  - WRITE: one cycle. im_we=1, im_addr=pointer, im_wdata=registered word, in_ready=0. Next cycle pointer++ and word_cnt++.
    - full asserts when word_cnt reaches DEPTH.
    - Go to DONE if the captured beat had in_last or DEPTH is now reached; else go to LOAD.
  - DONE: done=1, in_ready=0. Holds until start, which behaves as in IDLE.
- Latency: a beat accepted in cycle N is written with im_we in cycle N+1. Maximum throughput is 1 word per 2 cycles.
- Outputs: im_we, im_addr and im_wdata are registered. im_addr and im_wdata hold their last values when im_we=0.
- Full: once DEPTH words are written, no further beats are accepted. Remaining source beats are left unconsumed; the source handles that.
- start outside IDLE/DONE (mid-load) restarts: pointer and counters return to 0 next cycle, and any pending WRITE is dropped.
- reset_n low at any time returns all state and outputs to reset values immediately.
- in_valid without start in IDLE is ignored.

Decomposition:
- Shared package isa_pkg:
  - Type codes TYPE_MATH/COND/ASSIGN/VALUE.
  - Opcode enums for the math ops, cond ops (bl/bg/bne/beq), assign ops (li/load/store/cmp/nop) and value ops (mov/jmp).
  - Field-width constants.
  - The control decoder imports the same package.
- One combinational sub-module, instr_pack: inputs type/op/operand; outputs word[8:0] and legal. It is reusable by the bench as a reference model.

Test Plan:
- start; beats add(00,000,op=0x5), beq(01,011,op=0x12), li(10,000,op=0x9), jmp(11,001,op=0x3F, last) -> writes at addr 0..3 of 0x005, 0x0F2, 0x109, 0x1FF. word_cnt=4, done=1, error=0.
- Beat assign op 110 between two legal math beats -> two writes at addr 0,1 only, err_cnt=1, error=1. The illegal beat creates no im_we pulse.
- Cond beat with op=3'b100 or operand=0x20, and math beat with operand=0x10 -> all three rejected, err_cnt=3, no writes.
- DEPTH=4 build: stream 6 legal beats, none with in_last -> 4 writes (addr 0..3), full=1, done=1. in_ready stays 0 afterwards with beats 5 and 6 unconsumed.
- Hold in_valid=1 continuously -> in_ready toggles 1/0. im_we appears exactly one cycle after each accept, and one word is written per 2 cycles.
- Assert reset_n low during WRITE -> im_we drops immediately, all outputs 0. A later start rewrites from addr 0 with word_cnt=0.
